// File: rtl/tdes_round_ctrl.sv
// Sequencer for an iterative DES/3DES datapath: LOAD, 16 ROUNDs, FINAL per pass, then OUTV.
// A pass is 18 cycles; the result is held in OUTV until out_ready, and start is ignored while busy.
module tdes_round_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       decrypt,
  input  logic       tdes_en,
  input  logic       out_ready,
  output logic       busy,
  output logic       data_ld,
  output logic       chain_ld,
  output logic       key_ld,
  output logic [1:0] key_sel,
  output logic       rnd_en,
  output logic [1:0] key_shift,
  output logic       key_dir,
  output logic       fp_ld,
  output logic [3:0] round_idx,
  output logic [1:0] pass_idx,
  output logic       out_valid
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_ROUND = 3'd2,
    S_FINAL = 3'd3,
    S_OUTV  = 3'd4
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] round_q, round_d;
  logic [1:0] pass_q, pass_d;
  logic       dec_q, dec_d;
  logic       tdes_q, tdes_d;
  // Set for the first IDLE cycle after a handshake so a held start re-arms one cycle late.
  logic       hold_q, hold_d;

  logic       pass_dec;
  logic       last_pass;
  logic [1:0] pass_key;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      round_q <= 4'd0;
      pass_q  <= 2'd0;
      dec_q   <= 1'b0;
      tdes_q  <= 1'b0;
      hold_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      round_q <= round_d;
      pass_q  <= pass_d;
      dec_q   <= dec_d;
      tdes_q  <= tdes_d;
      hold_q  <= hold_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    round_d   = round_q;
    pass_d    = pass_q;
    dec_d     = dec_q;
    tdes_d    = tdes_q;
    hold_d    = 1'b0;
    busy      = 1'b0;
    data_ld   = 1'b0;
    chain_ld  = 1'b0;
    key_ld    = 1'b0;
    key_sel   = 2'd0;
    rnd_en    = 1'b0;
    key_shift = 2'd0;
    key_dir   = 1'b0;
    fp_ld     = 1'b0;
    out_valid = 1'b0;

    // EDE: the middle pass runs opposite to the requested direction; decrypt walks keys K3..K1.
    pass_dec  = tdes_q ? (dec_q ^ (pass_q == 2'd1)) : dec_q;
    last_pass = tdes_q ? (pass_q == 2'd2) : 1'b1;
    if (!tdes_q)    pass_key = 2'd0;
    else if (dec_q) pass_key = 2'd2 - pass_q;
    else            pass_key = pass_q;

    case (state_q)
      S_IDLE: begin
        if (start && !hold_q) begin
          dec_d   = decrypt;
          tdes_d  = tdes_en;
          pass_d  = 2'd0;
          round_d = 4'd0;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        busy    = 1'b1;
        key_ld  = 1'b1;
        key_sel = pass_key;
        if (pass_q == 2'd0) data_ld  = 1'b1;
        else                chain_ld = 1'b1;
        state_d = S_ROUND;
      end
      S_ROUND: begin
        busy    = 1'b1;
        rnd_en  = 1'b1;
        key_sel = pass_key;
        key_dir = pass_dec;
        // Decrypt starts from the post-encrypt C/D position, so its first round does not rotate.
        case (round_q)
          4'd0:                 key_shift = pass_dec ? 2'd0 : 2'd1;
          4'd1, 4'd8, 4'd15:    key_shift = 2'd1;
          default:              key_shift = 2'd2;
        endcase
        if (round_q == 4'd15) begin
          round_d = 4'd0;
          state_d = S_FINAL;
        end else begin
          round_d = round_q + 4'd1;
        end
      end
      S_FINAL: begin
        busy    = 1'b1;
        fp_ld   = 1'b1;
        key_sel = pass_key;
        if (last_pass) begin
          state_d = S_OUTV;
        end else begin
          pass_d  = pass_q + 2'd1;
          state_d = S_LOAD;
        end
      end
      S_OUTV: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) begin
          pass_d  = 2'd0;
          hold_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign round_idx = round_q;
  assign pass_idx  = pass_q;

endmodule

// File: tb/tb_tdes_round_ctrl.sv
// Directed/randomized bench for tdes_round_ctrl; expected strobes come from a cycle-offset model.
module tb_tdes_round_ctrl;

  logic       clk = 1'b0;
  logic       rst, start, decrypt, tdes_en, out_ready;
  logic       busy, data_ld, chain_ld, key_ld, rnd_en, key_dir, fp_ld, out_valid;
  logic [1:0] key_sel, key_shift, pass_idx;
  logic [3:0] round_idx;
  logic [17:0] obs;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  tdes_round_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .decrypt(decrypt), .tdes_en(tdes_en),
    .out_ready(out_ready), .busy(busy), .data_ld(data_ld), .chain_ld(chain_ld),
    .key_ld(key_ld), .key_sel(key_sel), .rnd_en(rnd_en), .key_shift(key_shift),
    .key_dir(key_dir), .fp_ld(fp_ld), .round_idx(round_idx), .pass_idx(pass_idx),
    .out_valid(out_valid)
  );

  assign obs = {busy, data_ld, chain_ld, key_ld, key_sel, rnd_en, key_shift,
                key_dir, fp_ld, round_idx, pass_idx, out_valid};

  // Expected outputs t cycles after the accepting cycle (t>=1): passes of 18 cycles, then OUTV.
  function automatic logic [17:0] model(input bit td, input bit dc, input int t);
    int np, p, ph, r;
    logic e_busy, e_dld, e_cld, e_kld, e_rnd, e_dir, e_fp, e_ov;
    logic [1:0] e_ksel, e_shift, e_pass;
    logic [3:0] e_round;
    bit pdec;
    e_busy = 0; e_dld = 0; e_cld = 0; e_kld = 0; e_rnd = 0; e_dir = 0; e_fp = 0; e_ov = 0;
    e_ksel = 0; e_shift = 0; e_pass = 0; e_round = 0;
    np = td ? 3 : 1;
    if (t >= 1) begin
      e_busy = 1;
      p = (t - 1) / 18;
      if (p < np) begin
        ph     = (t - 1) % 18;
        pdec   = td ? (dc ^ (p == 1)) : dc;
        e_pass = 2'(p);
        e_ksel = td ? (dc ? 2'(2 - p) : 2'(p)) : 2'd0;
        if (ph == 0) begin
          e_kld = 1;
          if (p == 0) e_dld = 1; else e_cld = 1;
        end else if (ph == 17) begin
          e_fp = 1;
        end else begin
          r       = ph - 1;
          e_rnd   = 1;
          e_round = 4'(r);
          e_dir   = pdec;
          if (r == 0)                          e_shift = pdec ? 2'd0 : 2'd1;
          else if (r == 1 || r == 8 || r == 15) e_shift = 2'd1;
          else                                 e_shift = 2'd2;
        end
      end else begin
        e_ov   = 1;
        e_pass = 2'(np - 1);
      end
    end
    return {e_busy, e_dld, e_cld, e_kld, e_ksel, e_rnd, e_shift, e_dir, e_fp,
            e_round, e_pass, e_ov};
  endfunction

  task automatic check(input string tag, input logic [17:0] e);
    n_tests++;
    assert (obs === e) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, e);
    end
  endtask

  task automatic check_int(input string tag, input int o, input int e);
    n_tests++;
    assert (o === e) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, o, e);
    end
  endtask

  // Accepts an operation in the current cycle and follows it to completion (or to a reset at rst_at).
  task automatic run_op(input bit td, input bit dc, input int stall, input bit hold,
                        input bit toggle, input int rst_at, input string name);
    int t, outv_n, first_ov;
    bit done;
    logic [17:0] e;
    @(negedge clk);
    check({name, "_idle_pre"}, 18'h0);
    start = 1; decrypt = dc; tdes_en = td; out_ready = 1'($urandom);
    t = 0; outv_n = 0; first_ov = -1; done = 0;
    while (!done) begin
      @(negedge clk);
      t++;
      if (t > 200) begin
        n_tests++; n_fail++;
        $error("FAIL %s_timeout observed=no_handshake expected=handshake", name);
        return;
      end
      e = model(td, dc, t);
      check($sformatf("%s_t%0d", name, t), e);
      if (t == rst_at) begin
        rst = 1; start = 1; out_ready = 1;
        @(negedge clk);
        check({name, "_after_rst"}, 18'h0);
        rst = 0; start = 0; out_ready = 0;
        return;
      end
      start = hold ? 1'b1 : 1'($urandom);
      if (toggle) begin
        decrypt = 1'($urandom);
        tdes_en = 1'($urandom);
      end
      if (e[0]) begin
        if (first_ov < 0) first_ov = t;
        out_ready = (outv_n == stall);
        if (outv_n == stall) done = 1;
        outv_n++;
      end else begin
        out_ready = 1'($urandom);
      end
    end
    check_int({name, "_latency"}, first_ov, td ? 55 : 19);
    @(negedge clk);
    check({name, "_idle_post"}, 18'h0);
    start = hold; out_ready = 0;
  endtask

  initial begin
    rst = 1; start = 1; decrypt = 1; tdes_en = 1; out_ready = 1;
    repeat (2) begin
      @(negedge clk);
      check("reset", 18'h0);
    end
    rst = 0; start = 0; decrypt = 0; tdes_en = 0; out_ready = 0;

    run_op(0, 0, 0, 0, 0, -1, "des_enc");
    run_op(0, 1, 0, 0, 0, -1, "des_dec");
    run_op(1, 1, 0, 0, 0, -1, "tdes_dec");
    run_op(1, 0, 10, 0, 0, -1, "tdes_enc_bp");
    run_op(0, 1, 10, 0, 0, -1, "des_bp");
    run_op(1, 1, 0, 0, 1, -1, "tdes_toggle");
    run_op(0, 0, 2, 0, 1, -1, "des_toggle");
    run_op(1, 0, 0, 0, 0, 9, "tdes_rst");
    run_op(1, 1, 0, 0, 0, -1, "after_rst");
    run_op(0, 0, 0, 1, 0, -1, "b2b_0");
    run_op(0, 1, 0, 1, 0, -1, "b2b_1");
    run_op(0, 0, 0, 0, 0, -1, "b2b_2");
    for (int i = 0; i < 6; i++)
      run_op(1'($urandom), 1'($urandom), int'($urandom_range(0, 3)), 0, 1'($urandom), -1,
             $sformatf("rand%0d", i));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
